pll_sweep_ctrl: RTL and testbench

- Table-driven sequencer for the PLL reconfiguration management port. It steps the memory-test clock through NSTEPS frequency settings, each with NC output counters.
- Replaces the fixed 11-entry, single-counter sweep logic in the SDRAM memtest top level.
- Adds per-step lock supervision with timeout, multi-counter C writes and a BCD elapsed-time counter.
- Sits in the CLK_50M domain between the keyboard/OSD command decode and the pll_cfg block.

---
 rtl/pll_sweep_ctrl_if.sv | 21 ++
 rtl/pll_sweep_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_pll_sweep_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_sweep_ctrl_if.sv
// PLL reconfiguration management port: write strobe, address, data and waitrequest.
interface pll_sweep_ctrl_if;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_write,
    output mgmt_address,
    output mgmt_writedata,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_write,
    input  mgmt_address,
    input  mgmt_writedata,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/pll_sweep_ctrl.sv
// Table-driven PLL reconfiguration sweep with lock supervision and BCD minute timer.
// Optional per-step dynamic phase write (address 6) enabled by defining DYN_PHASE_EN.
module pll_sweep_ctrl #(
  parameter int unsigned NSTEPS        = 11,
  parameter int unsigned NC            = 1,
  parameter int unsigned GAP           = 7,
  parameter int unsigned RST_CYC       = 8,
  parameter int unsigned LOCK_TIMEOUT  = 5000000,
  parameter int unsigned TICKS_PER_MIN = 32'd3000000000,
  parameter int unsigned CP            = 1,
  parameter int unsigned BW            = 7,
`ifdef DYN_PHASE_EN
  localparam int unsigned WPS          = 5 + NC
`else
  localparam int unsigned WPS          = 4 + NC
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NSTEPS*WPS*32-1:0]   cfg_table,
  input  logic                       cmd_up,
  input  logic                       cmd_down,
  input  logic                       cmd_reload,
  input  logic                       cmd_auto,
  input  logic                       advance_ok,
  input  logic                       locked,
  pll_sweep_ctrl_if.master           mgmt,
  output logic                       pll_reset,
  output logic                       busy,
  output logic [3:0]                 pos,
  output logic [15:0]                freq,
  output logic                       auto,
  output logic                       lock_err,
  output logic [15:0]                mins
);

  // start + table words M..(C/PHASE) + CP, BW, apply
  localparam int unsigned NWR = WPS + 3;
  localparam int unsigned TW  = NSTEPS * WPS * 32;
  localparam int unsigned TAW = $clog2(TW);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_GAP, S_RST, S_LOCK} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  pos_q, pos_d;
  logic        auto_q, auto_d;
  logic        err_q, err_d;
  logic [15:0] freq_q, freq_d;
  logic        start_q;
  logic [31:0] presc_q, presc_d;
  logic [15:0] mins_q, mins_d;
  logic        restart;
  logic [37:0] ent;
  logic [31:0] f_word;

  function automatic logic [31:0] tbl(input logic [3:0] s, input int unsigned w);
    int unsigned si;
    si = s;
    return cfg_table[TAW'((si * WPS + w) * 32) +: 32];
  endfunction

  function automatic logic [37:0] entry(input logic [3:0] s, input logic [3:0] i);
    int unsigned w;
    logic [31:0] word;
    w = i;
    if (w == 0) return '0;
    if (w < WPS) begin
      word = tbl(s, w);
      if (w == 1) return {6'd4, word};
      if (w == 2) return {6'd7, word};
      if (w == 3) return {6'd3, word};
      if (w < 4 + NC) return {6'd5, word | (32'(w - 4) << 18)};
      return {6'd6, word};
    end
    if (w == WPS)     return {6'd9, 32'(CP)};
    if (w == WPS + 1) return {6'd8, 32'(BW)};
    return {6'd2, 32'd0};
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
    else begin
      r[3:0] = '0;
      if (r[7:4] != 4'd9) r[7:4] = r[7:4] + 4'd1;
      else begin
        r[7:4] = '0;
        if (r[11:8] != 4'd9) r[11:8] = r[11:8] + 4'd1;
        else begin
          r[11:8] = '0;
          r[15:12] = (r[15:12] == 4'd9) ? 4'd0 : r[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign busy      = (state_q != S_IDLE) || start_q;
  assign pll_reset = (state_q == S_RST);
  assign pos       = pos_q;
  assign freq      = freq_q;
  assign auto      = auto_q;
  assign lock_err  = err_q;
  assign mins      = mins_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    auto_d  = auto_q;
    err_d   = err_q;
    freq_d  = freq_q;
    restart = start_q;
    f_word  = '0;
    ent     = entry(pos_q, idx_q);
    mgmt.mgmt_write     = 1'b0;
    mgmt.mgmt_address   = '0;
    mgmt.mgmt_writedata = '0;

    unique case (state_q)
      S_WR: begin
        mgmt.mgmt_address   = ent[37:32];
        mgmt.mgmt_writedata = ent[31:0];
        if (!mgmt.mgmt_waitrequest) begin
          mgmt.mgmt_write = 1'b1;
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP - 1) begin
          cnt_d = '0;
          if (idx_q == 4'(NWR - 1)) state_d = S_RST;
          else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_WR;
          end
        end else cnt_d = cnt_q + 32'd1;
      end
      S_RST: begin
        if (cnt_q == RST_CYC - 1) begin
          cnt_d   = '0;
          state_d = S_LOCK;
        end else cnt_d = cnt_q + 32'd1;
      end
      S_LOCK: begin
        if (locked) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end else if (cnt_q == LOCK_TIMEOUT - 1) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else cnt_d = cnt_q + 32'd1;
      end
      default: ;
    endcase

    // Ignored up/down requests leave pos, auto and any running sequence untouched.
    if (cmd_auto) begin
      pos_d   = '0;
      auto_d  = 1'b1;
      restart = 1'b1;
    end else if (cmd_reload) begin
      auto_d  = 1'b0;
      restart = 1'b1;
    end else if (cmd_up && !cmd_down) begin
      if (pos_q < 4'(NSTEPS - 1)) begin
        pos_d   = pos_q + 4'd1;
        auto_d  = 1'b0;
        restart = 1'b1;
      end
    end else if (cmd_down && !cmd_up) begin
      if (pos_q != 4'd0) begin
        pos_d   = pos_q - 4'd1;
        auto_d  = 1'b0;
        restart = 1'b1;
      end
    end else if (auto_q && advance_ok && state_q == S_IDLE && !start_q &&
                 pos_q < 4'(NSTEPS - 1)) begin
      pos_d   = pos_q + 4'd1;
      restart = 1'b1;
    end

    if (restart) begin
      state_d = S_WR;
      idx_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
      f_word  = tbl(pos_d, 0);
      freq_d  = f_word[15:0];
    end

    presc_d = presc_q + 32'd1;
    mins_d  = mins_q;
    if (busy) begin
      presc_d = '0;
      mins_d  = '0;
    end else if (presc_q == TICKS_PER_MIN - 1) begin
      presc_d = '0;
      mins_d  = bcd_inc(mins_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      auto_q  <= 1'b0;
      err_q   <= 1'b0;
      freq_q  <= '0;
      start_q <= 1'b1;
      presc_q <= '0;
      mins_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      auto_q  <= auto_d;
      err_q   <= err_d;
      freq_q  <= freq_d;
      start_q <= 1'b0;
      presc_q <= presc_d;
      mins_q  <= mins_d;
    end
  end

endmodule

// File: tb/tb_pll_sweep_ctrl.sv
// Directed self-checking bench for pll_sweep_ctrl (NSTEPS=4, NC=3, short timeouts).
module tb_pll_sweep_ctrl;

  localparam int NSTEPS = 4;
  localparam int NC     = 3;
`ifdef DYN_PHASE_EN
  localparam int WPS    = 5 + NC;
`else
  localparam int WPS    = 4 + NC;
`endif
  localparam int NWR    = WPS + 3;
  localparam int LTO    = 50;

  logic clk = 1'b0;
  logic rst_n;
  logic [NSTEPS*WPS*32-1:0] cfg_table;
  logic cmd_up, cmd_down, cmd_reload, cmd_auto, advance_ok, locked;
  logic pll_reset, busy, auto, lock_err;
  logic [3:0]  pos;
  logic [15:0] freq, mins;

  pll_sweep_ctrl_if mif ();

  pll_sweep_ctrl #(
    .NSTEPS(NSTEPS), .NC(NC), .GAP(7), .RST_CYC(8),
    .LOCK_TIMEOUT(LTO), .TICKS_PER_MIN(4), .CP(1), .BW(7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_table(cfg_table),
    .cmd_up(cmd_up), .cmd_down(cmd_down), .cmd_reload(cmd_reload), .cmd_auto(cmd_auto),
    .advance_ok(advance_ok), .locked(locked), .mgmt(mif),
    .pll_reset(pll_reset), .busy(busy), .pos(pos), .freq(freq),
    .auto(auto), .lock_err(lock_err), .mins(mins)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  logic [5:0]  q_addr[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];
  int rst_hi, busy_hi, last_rst_cyc, idle_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mif.mgmt_write) begin
      q_addr.push_back(mif.mgmt_address);
      q_data.push_back(mif.mgmt_writedata);
      q_cyc.push_back(cyc);
    end
    if (pll_reset) begin
      rst_hi++;
      last_rst_cyc = cyc;
    end
    if (busy) busy_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tw(input int s, input int w);
    return (32'(s) << 24) | (32'(w) << 12) | (32'(s) << 4) | 32'h5;
  endfunction

  // Hand-derived write list for NC=3, CP=1, BW=7.
  function automatic logic [37:0] exp_wr(input int s, input int j);
    int k;
    k = j;
`ifdef DYN_PHASE_EN
    if (j == 7) return {6'd6, tw(s, 7)};
    if (j > 7) k = j - 1;
`endif
    case (k)
      0: return {6'd0, 32'd0};
      1: return {6'd4, tw(s, 1)};
      2: return {6'd7, tw(s, 2)};
      3: return {6'd3, tw(s, 3)};
      4: return {6'd5, tw(s, 4)};
      5: return {6'd5, tw(s, 5) | 32'h0004_0000};
      6: return {6'd5, tw(s, 6) | 32'h0008_0000};
      7: return {6'd9, 32'd1};
      8: return {6'd8, 32'd7};
      default: return {6'd2, 32'd0};
    endcase
  endfunction

  task automatic clear_mon();
    q_addr.delete(); q_data.delete(); q_cyc.delete();
    rst_hi = 0; busy_hi = 0;
  endtask

  task automatic chk_seq(input int s, input int base);
    logic [37:0] e;
    for (int j = 0; j < NWR; j++) begin
      e = exp_wr(s, j);
      if (base + j < q_addr.size()) begin
        chk($sformatf("s%0d_w%0d_addr", s, j), 32'(q_addr[base + j]), 32'(e[37:32]));
        chk($sformatf("s%0d_w%0d_data", s, j), q_data[base + j], e[31:0]);
        if (j > 0)
          chk($sformatf("s%0d_w%0d_gap", s, j), 32'(q_cyc[base + j] - q_cyc[base + j - 1]), 32'd8);
      end else
        chk($sformatf("s%0d_w%0d_present", s, j), 32'd0, 32'd1);
    end
  endtask

  task automatic pulse(input logic up, input logic dn, input logic rl, input logic au);
    @(posedge clk); #1;
    cmd_up = up; cmd_down = dn; cmd_reload = rl; cmd_auto = au;
    @(posedge clk); #1;
    cmd_up = 0; cmd_down = 0; cmd_reload = 0; cmd_auto = 0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < maxc);
    idle_cyc = cyc;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic found;
    int n;
    rst_n = 0; cmd_up = 0; cmd_down = 0; cmd_reload = 0; cmd_auto = 0;
    advance_ok = 0; locked = 0; mif.mgmt_waitrequest = 0;
    for (int s = 0; s < NSTEPS; s++)
      for (int w = 0; w < WPS; w++)
        cfg_table[(s*WPS + w)*32 +: 32] = tw(s, w);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_write", 32'(mif.mgmt_write), 32'd0);
    chk("rst_pllrst", 32'(pll_reset), 32'd0);
    chk("rst_auto", 32'(auto), 32'd0);
    chk("rst_lockerr", 32'(lock_err), 32'd0);
    chk("rst_mins", 32'(mins), 32'd0);
    chk("rst_freq", 32'(freq), 32'd0);

    // power-on sequence for step 0
    @(posedge clk); #1;
    clear_mon();
    rst_n = 1;
    repeat (10) @(posedge clk);
    #1 locked = 1;
    wait_idle(400, "seq0");
    chk("seq0_nwr", 32'(q_addr.size()), 32'(NWR));
    chk_seq(0, 0);
    chk("seq0_rst_cyc", 32'(rst_hi), 32'd8);
    chk("seq0_lockerr", 32'(lock_err), 32'd0);
    chk("seq0_freq", 32'(freq), {16'd0, tw(0, 0)[15:0]});
    chk("seq0_auto", 32'(auto), 32'd0);

    // cmd_down at the bottom is ignored
    clear_mon();
    pulse(0, 1, 0, 0);
    repeat (20) @(negedge clk);
    chk("down0_nwr", 32'(q_addr.size()), 32'd0);
    chk("down0_busy", 32'(busy_hi), 32'd0);
    chk("down0_pos", 32'(pos), 32'd0);

    // reload, then cmd_up in the GAP after the address-7 write
    clear_mon();
    pulse(0, 0, 1, 0);
    found = 0;
    n = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      if (mif.mgmt_write && mif.mgmt_address == 6'd7) found = 1;
    end
    chk("a7_seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    pulse(1, 0, 0, 0);
    @(negedge clk);
    chk("up_pos", 32'(pos), 32'd1);
    chk("up_freq", 32'(freq), {16'd0, tw(1, 0)[15:0]});
    chk("up_busy", 32'(busy), 32'd1);
    chk("up_pllrst", 32'(pll_reset), 32'd0);
    wait_idle(400, "seq1");
    chk("seq1_nwr", 32'(q_addr.size()), 32'(3 + NWR));
    chk_seq(1, 3);
    chk("seq1_rst_cyc", 32'(rst_hi), 32'd8);

    // auto sweep from step 0 to the last step
    clear_mon();
    advance_ok = 1;
    pulse(0, 0, 0, 1);
    @(negedge clk);
    chk("auto_pos0", 32'(pos), 32'd0);
    chk("auto_on", 32'(auto), 32'd1);
    n = 0;
    while (!(pos == 4'(NSTEPS - 1) && !busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("auto_done", 32'(busy), 32'd0);
    chk("auto_pos_end", 32'(pos), 32'(NSTEPS - 1));
    chk("auto_still_on", 32'(auto), 32'd1);
    chk("auto_nwr", 32'(q_addr.size()), 32'(NSTEPS * NWR));
    for (int s = 0; s < NSTEPS; s++) chk_seq(s, s * NWR);
    chk("auto_rst_cyc", 32'(rst_hi), 32'(NSTEPS * 8));
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("mins_40", 32'(mins), 32'h0010);
    chk("auto_stop_nwr", 32'(q_addr.size()), 32'(NSTEPS * NWR));

    // cmd_up at the top, and up+down together, are ignored
    clear_mon();
    pulse(1, 0, 0, 0);
    repeat (10) @(negedge clk);
    pulse(1, 1, 0, 0);
    repeat (10) @(negedge clk);
    chk("top_nwr", 32'(q_addr.size()), 32'd0);
    chk("top_busy", 32'(busy_hi), 32'd0);
    chk("top_pos", 32'(pos), 32'(NSTEPS - 1));

    // lock timeout, with waitrequest stalling the first write
    advance_ok = 0;
    locked = 0;
    clear_mon();
    pulse(0, 1, 0, 0);
    mif.mgmt_waitrequest = 1;
    repeat (5) @(negedge clk);
    chk("wreq_stall", 32'(q_addr.size()), 32'd0);
    @(posedge clk); #1;
    mif.mgmt_waitrequest = 0;
    wait_idle(600, "tmo");
    chk("tmo_lockerr", 32'(lock_err), 32'd1);
    chk("tmo_pos", 32'(pos), 32'(NSTEPS - 2));
    chk("tmo_auto", 32'(auto), 32'd0);
    chk("tmo_len", 32'(idle_cyc - last_rst_cyc), 32'(LTO + 1));
    chk("tmo_nwr", 32'(q_addr.size()), 32'(NWR));

    // recovery clears lock_err at sequence start
    locked = 1;
    pulse(0, 0, 1, 0);
    @(negedge clk);
    chk("rl_lockerr_clr", 32'(lock_err), 32'd0);
    wait_idle(400, "rl");
    chk("rl_lockerr", 32'(lock_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
